// File: rtl/bf_exec_ctrl.sv
// TinyBF execution controller: button conditioning, run/pause/step FSM,
// breakpoint, watchdog and stop-cause reporting.
module bf_exec_ctrl #(
  parameter int ADDR_W = 4,
  parameter int WDOG_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_btn_i,
  input  logic              halt_btn_i,
  input  logic              step_btn_i,
  input  logic              step_mode_i,
  input  logic              bkpt_en_i,
  input  logic [ADDR_W-1:0] bkpt_pc_i,
  input  logic [WDOG_W-1:0] wdog_limit_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              cpu_busy_i,
  output logic              cpu_start_o,
  output logic              cpu_halt_o,
  output logic              cpu_en_o,
  output logic [2:0]        state_o,
  output logic [1:0]        halt_cause_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_PAUSE = 3'd2,
    S_STEP  = 3'd3,
    S_STOP  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    C_DONE = 2'd0,
    C_USER = 2'd1,
    C_BKPT = 2'd2,
    C_WDOG = 2'd3
  } cause_t;

  // Bit order in the sync chain: {step, halt, start}
  logic [2:0] r_sync1;
  logic [2:0] r_sync2;
  logic [2:0] r_sync3;
  logic [2:0] w_ev;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_sync3 <= '0;
    end else begin
      r_sync1 <= {step_btn_i, halt_btn_i, start_btn_i};
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  assign w_ev = r_sync2 & ~r_sync3;

  logic w_start_ev;
  logic w_halt_ev;
  logic w_step_ev;

  assign w_start_ev = w_ev[0];
  assign w_halt_ev  = w_ev[1];
  assign w_step_ev  = w_ev[2];

  state_t            r_state;
  cause_t            r_cause;
  logic              r_start;
  logic              r_halt;
  logic              r_en;
  logic              r_seen;
  logic [WDOG_W-1:0] r_wdog;
  logic [ADDR_W-1:0] r_pc_q;

  logic w_wdog_hit;
  logic w_bkpt_hit;
  logic w_done;

  assign w_wdog_hit = (wdog_limit_i != '0)
                   && (r_wdog == wdog_limit_i);
  assign w_bkpt_hit = bkpt_en_i
                   && (pc_i == bkpt_pc_i)
                   && (pc_i != r_pc_q);
  assign w_done     = r_seen && !cpu_busy_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
      r_cause <= C_DONE;
      r_start <= 1'b0;
      r_halt  <= 1'b0;
      r_en    <= 1'b0;
      r_seen  <= 1'b0;
      r_wdog  <= '0;
      r_pc_q  <= '0;
    end else begin
      r_start <= 1'b0;
      r_halt  <= 1'b0;
      r_pc_q  <= pc_i;
      if (r_en && (r_wdog != '1))
        r_wdog <= r_wdog + WDOG_W'(1);
      unique case (r_state)
        S_IDLE, S_STOP: begin
          if (w_start_ev) begin
            r_start <= 1'b1;
            r_wdog  <= '0;
            r_seen  <= 1'b0;
            r_state <= step_mode_i ? S_PAUSE : S_RUN;
            r_en    <= !step_mode_i;
          end
        end
        S_RUN: begin
          if (cpu_busy_i)
            r_seen <= 1'b1;
          if (w_halt_ev) begin
            r_halt  <= 1'b1;
            r_state <= S_STOP;
            r_cause <= C_USER;
            r_en    <= 1'b0;
          end else if (w_wdog_hit) begin
            r_halt  <= 1'b1;
            r_state <= S_STOP;
            r_cause <= C_WDOG;
            r_en    <= 1'b0;
          end else if (w_bkpt_hit) begin
            r_state <= S_PAUSE;
            r_cause <= C_BKPT;
            r_en    <= 1'b0;
          end else if (w_done) begin
            r_state <= S_IDLE;
            r_cause <= C_DONE;
            r_en    <= 1'b0;
          end
        end
        S_PAUSE: begin
          if (w_halt_ev) begin
            r_halt  <= 1'b1;
            r_state <= S_STOP;
            r_cause <= C_USER;
          end else if (w_start_ev) begin
            r_state <= S_RUN;
            r_en    <= 1'b1;
          end else if (w_step_ev) begin
            r_state <= S_STEP;
            r_en    <= 1'b1;
          end
        end
        S_STEP: begin
          // A stepped instruction can also be the one that ends the program
          if (cpu_busy_i)
            r_seen <= 1'b1;
          r_en <= 1'b0;
          if (w_done) begin
            r_state <= S_IDLE;
            r_cause <= C_DONE;
          end else begin
            r_state <= S_PAUSE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_en    <= 1'b0;
        end
      endcase
    end
  end

  assign cpu_start_o  = r_start;
  assign cpu_halt_o   = r_halt;
  assign cpu_en_o     = r_en;
  assign state_o      = r_state;
  assign halt_cause_o = r_cause;

endmodule
